// File: rtl/seg_scan_driver.sv
`default_nettype none
// ============================================================================
// Module   : seg_scan_driver
// Brief    : Time-multiplexes six 3-bit note IDs onto a common-anode 6-digit
//            seven-segment display, with anti-ghost blanking and frame tick.
// Revision : 1.0 - initial release
// ============================================================================
module seg_scan_driver #(
    parameter int SCAN_DIV     = 50000,
    parameter int BLANK_CYCLES = 500
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] data_seg1,
    input  logic [2:0] data_seg2,
    input  logic [2:0] data_seg3,
    input  logic [2:0] data_seg4,
    input  logic [2:0] data_seg5,
    input  logic [2:0] data_seg6,
    input  logic [5:0] dp_en,
    output logic [5:0] digit_sel_n,
    output logic [7:0] seg_n,
    output logic       frame_tick
);

    localparam int               CNT_W      = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] C_CNT_SNAP = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [CNT_W-1:0] C_CNT_SHOW = CNT_W'(BLANK_CYCLES);
    localparam logic [2:0]       C_IDX_LAST = 3'd5;

    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_idx;
    logic [2:0]       r_code;
    logic             r_dp;
    logic [5:0]       r_digit_sel_n;
    logic [7:0]       r_seg_n;
    logic             r_frame_tick;

    logic             w_slot_end;
    logic             w_show;
    logic [2:0]       w_code_in;
    logic             w_dp_in;
    logic [6:0]       w_pattern;

    assign w_slot_end = (r_cnt == C_CNT_LAST);
    assign w_show     = (r_cnt >= C_CNT_SHOW);

    always_comb begin
        w_code_in = 3'd0;
        w_dp_in   = 1'b0;
        case (r_idx)
            3'd0: begin w_code_in = data_seg1; w_dp_in = dp_en[0]; end
            3'd1: begin w_code_in = data_seg2; w_dp_in = dp_en[1]; end
            3'd2: begin w_code_in = data_seg3; w_dp_in = dp_en[2]; end
            3'd3: begin w_code_in = data_seg4; w_dp_in = dp_en[3]; end
            3'd4: begin w_code_in = data_seg5; w_dp_in = dp_en[4]; end
            3'd5: begin w_code_in = data_seg6; w_dp_in = dp_en[5]; end
            default: begin w_code_in = 3'd0; w_dp_in = 1'b0; end
        endcase
    end

    // Numbered-notation numerals 1..7; code 0 leaves the digit dark.
    always_comb begin
        w_pattern = 7'h00;
        case (r_code)
            3'd0: w_pattern = 7'h00;
            3'd1: w_pattern = 7'h06;
            3'd2: w_pattern = 7'h5B;
            3'd3: w_pattern = 7'h4F;
            3'd4: w_pattern = 7'h66;
            3'd5: w_pattern = 7'h6D;
            3'd6: w_pattern = 7'h7D;
            3'd7: w_pattern = 7'h07;
            default: w_pattern = 7'h00;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt         <= '0;
            r_idx         <= 3'd0;
            r_code        <= 3'd0;
            r_dp          <= 1'b0;
            r_digit_sel_n <= 6'h3F;
            r_seg_n       <= 8'hFF;
            r_frame_tick  <= 1'b0;
        end else begin
            if (w_slot_end) begin
                r_cnt <= '0;
                r_idx <= (r_idx == C_IDX_LAST) ? 3'd0 : r_idx + 3'd1;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end

            // Snapshot on the last blank cycle so the whole SHOW phase is stable.
            if (r_cnt == C_CNT_SNAP) begin
                r_code <= w_code_in;
                r_dp   <= w_dp_in;
            end

            if (w_show) begin
                r_digit_sel_n <= ~(6'd1 << r_idx);
                r_seg_n       <= ~{r_dp, w_pattern};
            end else begin
                r_digit_sel_n <= 6'h3F;
                r_seg_n       <= 8'hFF;
            end

            r_frame_tick <= w_slot_end && (r_idx == C_IDX_LAST);
        end
    end

    assign digit_sel_n = r_digit_sel_n;
    assign seg_n       = r_seg_n;
    assign frame_tick  = r_frame_tick;

endmodule
`default_nettype wire

// File: tb/tb_seg_scan_driver.sv
`default_nettype none
// ============================================================================
// Module   : tb_seg_scan_driver
// Brief    : Directed stimulus with a queued scoreboard for seg_scan_driver.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seg_scan_driver;

    localparam int C_DIV   = 8;
    localparam int C_BLANK = 2;
    localparam int C_SHOW  = C_DIV - C_BLANK;
    localparam int C_FRAME = 6 * C_DIV;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] data_seg1 = 3'd0, data_seg2 = 3'd0, data_seg3 = 3'd0;
    logic [2:0] data_seg4 = 3'd0, data_seg5 = 3'd0, data_seg6 = 3'd0;
    logic [5:0] dp_en = 6'd0;
    logic [5:0] digit_sel_n;
    logic [7:0] seg_n;
    logic       frame_tick;

    int errors = 0;
    int checks = 0;

    logic [13:0] exp_q[$];
    logic [13:0] cur_exp = 14'h0;
    logic        rst_seen_low = 1'b1;
    bit          in_show = 1'b0;
    int          show_run = 0;
    int          blank_run = 0;
    int          cyc = 0;

    seg_scan_driver #(
        .SCAN_DIV     (C_DIV),
        .BLANK_CYCLES (C_BLANK)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .data_seg1   (data_seg1),
        .data_seg2   (data_seg2),
        .data_seg3   (data_seg3),
        .data_seg4   (data_seg4),
        .data_seg5   (data_seg5),
        .data_seg6   (data_seg6),
        .dp_en       (dp_en),
        .digit_sel_n (digit_sel_n),
        .seg_n       (seg_n),
        .frame_tick  (frame_tick)
    );

    always #5 clk = ~clk;

    always @(posedge clk) rst_seen_low = !rst_n;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endfunction

    // Monitor: samples on the falling edge, pops one expectation per digit window.
    always @(negedge clk) begin
        if (rst_seen_low) begin
            check("reset_sel", 32'(digit_sel_n), 32'h3F);
            check("reset_seg", 32'(seg_n), 32'hFF);
            check("reset_tick", 32'(frame_tick), 32'h0);
            in_show   = 1'b0;
            show_run  = 0;
            blank_run = 0;
            cyc       = 0;
        end else begin
            cyc++;
            if (frame_tick) begin
                check("tick_period", 32'(cyc), 32'(C_FRAME));
                cyc = 0;
            end
            if (digit_sel_n != 6'h3F) begin
                if (!in_show) begin
                    check("blank_len", 32'(blank_run), 32'(C_BLANK));
                    if (exp_q.size() == 0) begin
                        check("queue_underflow", 32'(digit_sel_n), 32'h3F);
                        cur_exp = {digit_sel_n, 8'hEE};
                    end else begin
                        cur_exp = exp_q.pop_front();
                    end
                    in_show  = 1'b1;
                    show_run = 0;
                end
                show_run++;
                check("sel", 32'(digit_sel_n), 32'(cur_exp[13:8]));
                check("seg", 32'(seg_n), 32'(cur_exp[7:0]));
            end else begin
                check("blank_seg", 32'(seg_n), 32'hFF);
                if (in_show) begin
                    check("show_len", 32'(show_run), 32'(C_SHOW));
                    in_show   = 1'b0;
                    blank_run = 0;
                end
                blank_run++;
            end
        end
    end

    task automatic set_data(input logic [2:0] d1, d2, d3, d4, d5, d6, input logic [5:0] dp);
        data_seg1 = d1; data_seg2 = d2; data_seg3 = d3;
        data_seg4 = d4; data_seg5 = d5; data_seg6 = d6;
        dp_en = dp;
    endtask

    task automatic push_frame(input logic [7:0] s1, s2, s3, s4, s5, s6);
        exp_q.push_back({6'h3E, s1});
        exp_q.push_back({6'h3D, s2});
        exp_q.push_back({6'h3B, s3});
        exp_q.push_back({6'h37, s4});
        exp_q.push_back({6'h2F, s5});
        exp_q.push_back({6'h1F, s6});
    endtask

    task automatic wait_tick();
        bit got = 1'b0;
        for (int i = 0; i < 3 * C_FRAME && !got; i++) begin
            @(negedge clk);
            if (frame_tick) got = 1'b1;
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL tick_timeout: got none expected pulse at %0t", $time);
        end
    endtask

    task automatic wait_sel(input logic [5:0] sel);
        bit got = 1'b0;
        for (int i = 0; i < 3 * C_FRAME && !got; i++) begin
            @(negedge clk);
            if (digit_sel_n == sel) got = 1'b1;
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL sel_timeout: got %h expected %h", digit_sel_n, sel);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Frame 0: reset for 3 cycles, everything dark but scanning.
        set_data(3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 6'h00);
        push_frame(8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        wait_tick();

        // Frame 1: numerals 1..6.
        set_data(3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 6'h00);
        push_frame(8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82);
        wait_tick();

        // Frame 2: code 7 and code 0.
        set_data(3'd7, 3'd0, 3'd3, 3'd4, 3'd5, 3'd6, 6'h00);
        push_frame(8'hF8, 8'hFF, 8'hB0, 8'h99, 8'h92, 8'h82);
        wait_tick();

        // Frame 3: SEG3 input changes mid-slot; the snapshot must hold.
        set_data(3'd1, 3'd2, 3'd2, 3'd4, 3'd5, 3'd6, 6'h00);
        push_frame(8'hF9, 8'hA4, 8'hA4, 8'h99, 8'h92, 8'h82);
        wait_sel(6'h3B);
        @(negedge clk);
        data_seg3 = 3'd5;
        wait_tick();

        // Frame 4: new SEG3 value appears; dp on a blank SEG1.
        set_data(3'd0, 3'd2, 3'd5, 3'd4, 3'd5, 3'd6, 6'b000001);
        push_frame(8'h7F, 8'hA4, 8'h92, 8'h99, 8'h92, 8'h82);
        wait_tick();

        // Frame 5: dp on SEG6 showing 3.
        set_data(3'd0, 3'd2, 3'd5, 3'd4, 3'd5, 3'd3, 6'b100000);
        push_frame(8'hFF, 8'hA4, 8'h92, 8'h99, 8'h92, 8'h30);
        wait_tick();

        // Frame 6: one-cycle reset during SEG4 SHOW, then a full clean frame.
        set_data(3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 6'h00);
        exp_q.push_back({6'h3E, 8'hF9});
        exp_q.push_back({6'h3D, 8'hA4});
        exp_q.push_back({6'h3B, 8'hB0});
        exp_q.push_back({6'h37, 8'h99});
        wait_sel(6'h37);
        @(negedge clk);
        rst_n = 1'b0;
        push_frame(8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82);
        @(negedge clk);
        rst_n = 1'b1;
        wait_tick();

        repeat (2) @(negedge clk);
        check("queue_drained", 32'(exp_q.size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/seg_scan_driver.md
Name: seg_scan_driver

Overview:
- Reader-side counterpart of the scrolling note buffer. Consumes the six registered 3-bit note IDs for SEG1..SEG6 and time-multiplexes them onto a common-anode 6-digit seven-segment display.
- Each note ID is shown as its numbered-notation numeral 1..7. ID 0 is shown as a dark digit.
- Includes a scan prescaler, per-slot data snapshot, anti-ghosting blanking and a frame tick for downstream pacing.

Parameters:
- SCAN_DIV, 50000: clk cycles per digit slot (1 kHz per digit at 50 MHz). Legal when ≥ 4.
- BLANK_CYCLES, 500: cycles at the start of each slot with all digits and segments off. Legal when 1 ≤ BLANK_CYCLES < SCAN_DIV.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, synchronous, active-low
- data_seg1  in  3  note ID for SEG1 (rightmost); 0 = blank, 1..7 = numeral
- data_seg2  in  3  note ID for SEG2
- data_seg3  in  3  note ID for SEG3
- data_seg4  in  3  note ID for SEG4
- data_seg5  in  3  note ID for SEG5
- data_seg6  in  3  note ID for SEG6 (leftmost)
- dp_en  in  6  per-digit decimal point enable; bit k belongs to SEG(k+1)
- digit_sel_n  out  6  active-low one-hot digit enable; bit k drives SEG(k+1)
- seg_n  out  8  active-low segments {dp,g,f,e,d,c,b,a}; bit7 = dp, bit0 = a
- frame_tick  out  1  one-cycle pulse at the end of each complete 6-digit scan

Behaviour:
- Reset: one clock with rst_n=0 sets the following. There is no asynchronous path.
  - slot counter cnt=0, digit index idx=0, snapshot code=0, snapshot dp=0.
  - digit_sel_n=6'h3F, seg_n=8'hFF, frame_tick=0.
- Reset asserted mid-slot or mid-frame: all state is discarded at that edge. Scan restarts at SEG1, cnt=0, on the first cycle with rst_n=1.
- Slot counter:
  - cnt counts 0..SCAN_DIV-1 and increments every cycle.
  - At cnt==SCAN_DIV-1: cnt→0 and idx→idx+1. idx wraps 5→0 and never holds a value above 5.
  - cnt width is clog2(SCAN_DIV).
- Slot phases, on the internal cnt:
  - BLANK phase: cnt in [0, BLANK_CYCLES-1].
  - SHOW phase: cnt in [BLANK_CYCLES, SCAN_DIV-1].
- Snapshot:
  - At cnt==BLANK_CYCLES-1, latch code ← data_seg(idx+1) and dp ← dp_en[idx].
  - Input changes at any other time have no effect on the current slot; they appear at that digit's next slot.
- Outputs are registered, with one cycle of latency from internal state:
  - Cycle t+1 reflects cnt/idx/snapshot at cycle t.
  - During SHOW: digit_sel_n = ~(6'b1 << idx) and seg_n = ~{dp, pattern(code)}.
  - During BLANK: digit_sel_n=6'h3F and seg_n=8'hFF.
  - Never more than one digit_sel_n bit is low.
- pattern(code), {g..a} active-high:
  - 0→7'h00
  - 1→7'h06
  - 2→7'h5B
  - 3→7'h4F
  - 4→7'h66
  - 5→7'h6D
  - 6→7'h7D
  - 7→7'h07
  - All 8 codes are defined. There is no illegal input.
- Blank code with dp: code 0 with dp=1 gives seg_n=8'h7F, i.e. only the dp segment lit. The digit is still selected.
- frame_tick:
  - Registered; high for exactly one cycle.
  - It follows, with one cycle of latency, the internal cycle where idx==5 and cnt==SCAN_DIV-1.
  - Period is 6*SCAN_DIV cycles.
- Timing per slot:
  - digit_sel_n is low for exactly SCAN_DIV-BLANK_CYCLES consecutive cycles.
  - It is high for exactly BLANK_CYCLES cycles between consecutive digits, including the wrap from SEG6 to SEG1.

Test Plan (SCAN_DIV=8, BLANK_CYCLES=2 unless stated):
- Reset and cadence:
  - Stimulus: hold rst_n=0 for 3 cycles, then release. Set all data=0 and dp_en=0.
  - Required: digit_sel_n=3F and seg_n=FF while in reset.
  - Required after release: digit_sel_n cycles 3E,3D,3B,37,2F,1F, each for 6 cycles, separated by 2 cycles of 3F. seg_n stays FF.
  - Required: frame_tick pulses every 48 cycles.
- Decode of all codes:
  - Stimulus: data_seg1..6 = 1,2,3,4,5,6. Then repeat with data_seg1=7 and data_seg2=0.
  - Required: seg_n during SHOW equals F9,A4,B0,99,92,82 for SEG1..SEG6.
  - Required on repeat: SEG1 shows F8 and SEG2 shows FF while digit_sel_n=3D.
- Snapshot stability:
  - Stimulus: data_seg3 changes 2→5 at cnt=4 of SEG3's slot.
  - Required: SEG3 shows A4 for the rest of that slot and 92 in the next frame.
- Decimal point:
  - Stimulus: dp_en=6'b000001 with data_seg1=0, then dp_en=6'b100000 with data_seg6=3.
  - Required: SEG1 shows 7F; SEG6 shows 30.
  - Required: no other digit has bit7 low.
- Mid-frame reset:
  - Stimulus: pull rst_n low for 1 cycle during SEG4's SHOW phase.
  - Required: the next edge gives 3F/FF. After release, the scan restarts at SEG1 with 2 blank cycles.
  - Required: the first frame_tick comes 48 cycles after release, and no earlier pulse occurs.
- Default parameters:
  - Stimulus: run 2 full frames.
  - Required: 300000-cycle frame_tick period; each digit low for 49500 cycles and blanked for 500.
